// File: rtl/y86_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : y86_pkg                                                        |
// | Purpose   : Shared Y86-64 definitions used by the memory-access stage:     |
// |             instruction codes, the memory-phase FSM state encoding and     |
// |             small icode classification helpers.                            |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package y86_pkg;

  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Instructions that store a word to data memory.
  function automatic logic icode_is_write(input logic [3:0] icode);
    return (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
  endfunction

  // Instructions that load a word from data memory.
  function automatic logic icode_is_read(input logic [3:0] icode);
    return (icode == ICODE_MRMOVQ) || (icode == ICODE_RET) || (icode == ICODE_POPQ);
  endfunction

  // Stack pops take their address from valA (the old stack pointer);
  // everything else addresses memory through valE.
  function automatic logic icode_addr_from_vala(input logic [3:0] icode);
    return (icode == ICODE_RET) || (icode == ICODE_POPQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : dmem_byte_ram                                                  |
// | Purpose   : Byte-wide single-port data RAM, synchronous write and          |
// |             combinational (asynchronous) read. Contents are never reset.   |
// | Ports     : clk      - write clock                                         |
// |             i_we     - write enable, byte written on rising edge           |
// |             i_addr   - byte address (read and write share it)              |
// |             i_wdata  - write byte                                          |
// |             o_rdata  - read byte at i_addr                                 |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module dmem_byte_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : mem_access                                                     |
// | Purpose   : Y86-64 memory stage. Moves one 64-bit little-endian word       |
// |             between the pipeline and a byte-wide RAM, one byte per cycle.  |
// |             Stores: rmmovq/pushq (valE <- valA), call (valE <- valP).      |
// |             Loads : mrmovq (valE), ret/popq (valA).                        |
// |             Other icodes complete in one cycle without touching memory.    |
// | Ports     : clk, rst (sync, active-high), start, icode[3:0], valE/valA/    |
// |             valP[63:0] inputs; busy, done (1-cycle pulse), valM[63:0],     |
// |             dmem_error outputs.                                            |
// | Config    : DMEM_BOUNDS_CHECK_EN - when defined, accesses whose base       |
// |             address exceeds MEM_BYTES-8 fault (no transfer, dmem_error=1). |
// |             When undefined, byte addresses wrap modulo MEM_BYTES and       |
// |             dmem_error is constant 0.                                      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module mem_access
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        dmem_error
);

  localparam int ADDR_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  mem_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        icode_q, icode_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;     // byte address of the current XFER cycle
  logic [63:0]       data_q, data_d;   // store data, shifted right one byte per cycle
  logic [55:0]       rbuf_q, rbuf_d;   // first seven loaded bytes, newest at the top
  logic [63:0]       valm_q, valm_d;

  logic [63:0]       w_addr;
  logic [63:0]       w_sdata;
  logic              w_access;
  logic              w_fault;
  logic [ADDR_W-1:0] w_base;
  logic              w_we;
  logic [7:0]        w_rdata;

  // Operand selection from the live inputs; only consumed on the start edge.
  assign w_addr   = icode_addr_from_vala(icode) ? valA : valE;
  assign w_sdata  = (icode == ICODE_CALL) ? valP : valA;
  assign w_access = icode_is_write(icode) || icode_is_read(icode);

`ifdef DMEM_BOUNDS_CHECK_EN
  // In-range bases satisfy addr <= MEM_BYTES-8, so the low bits are the index
  // and addr+7 never leaves the array.
  assign w_fault = w_access && (w_addr > 64'(MEM_BYTES - 8));
  assign w_base  = w_addr[ADDR_W-1:0];
`else
  assign w_fault = 1'b0;
  assign w_base  = ADDR_W'(w_addr % 64'(MEM_BYTES));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    rbuf_d  = rbuf_q;
    valm_d  = valm_q;
    w_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          icode_d = icode;
          ptr_d   = w_base;
          data_d  = w_sdata;
          cnt_d   = 3'd0;
          state_d = (w_access && !w_fault) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        w_we   = icode_is_write(icode_q);
        data_d = data_q >> 8;
        rbuf_d = {w_rdata, rbuf_q[55:8]};
        // Incrementing pointer with explicit wrap so MEM_BYTES need not be a power of two.
        ptr_d  = (ptr_q == ADDR_W'(MEM_BYTES - 1)) ? '0 : ptr_q + ADDR_W'(1);
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
          if (icode_is_read(icode_q)) begin
            valm_d = {w_rdata, rbuf_q};
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      icode_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      rbuf_q  <= '0;
      valm_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      rbuf_q  <= rbuf_d;
      valm_q  <= valm_d;
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  logic err_q, err_d;

  // Refreshed on every entry to DONE: only a direct IDLE->DONE can be a fault.
  always_comb begin
    err_d = err_q;
    if (state_d == ST_DONE) begin
      err_d = (state_q == ST_IDLE) && w_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign dmem_error = err_q;
`else
  assign dmem_error = 1'b0;
`endif

  // Reset has priority: the byte of the XFER cycle that sees rst is not written.
  dmem_byte_ram #(
    .DEPTH  (MEM_BYTES),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we && !rst),
    .i_addr  (ptr_q),
    .i_wdata (data_q[7:0]),
    .o_rdata (w_rdata)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign valM = valm_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_mem_access                                                  |
// | Purpose   : Self-checking bench for mem_access: directed scenarios with    |
// |             literal expectations plus randomized traffic compared every    |
// |             cycle against a transaction-level reference model.             |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_mem_access;

  localparam int MEM_BYTES = 1024;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [63:0] valE  = '0;
  logic [63:0] valA  = '0;
  logic [63:0] valP  = '0;
  logic        busy, done, dmem_error;
  logic [63:0] valM;

  mem_access #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .icode      (icode),
    .valE       (valE),
    .valA       (valA),
    .valP       (valP),
    .busy       (busy),
    .done       (done),
    .valM       (valM),
    .dmem_error (dmem_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // 'left' counts cycles remaining in the current phase: 9 for a transfer
  // (8 byte cycles + completion), 1 for an immediate completion, 0 when idle.
  int          left = 0;
  int          bi;
  logic        op_wr, op_rd;
  logic [63:0] op_addr, op_data;
  logic [63:0] m_valM = '0;
  logic        m_err  = 1'b0;
  logic [7:0]  m_mem [MEM_BYTES];

  function automatic int baddr(input logic [63:0] a, input int i);
    return int'(((a % 64'(MEM_BYTES)) + 64'(i)) % 64'(MEM_BYTES));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      left   = 0;
      m_valM = '0;
      m_err  = 1'b0;
    end else if (left == 0) begin
      if (start) begin
        op_wr   = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
        op_rd   = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
        op_addr = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
        op_data = (icode == 4'h8) ? valP : valA;
        if (!(op_wr || op_rd)) begin
          left  = 1;
          m_err = 1'b0;
        end else if (BC && (op_addr > 64'(MEM_BYTES - 8))) begin
          left  = 1;
          m_err = 1'b1;
        end else begin
          left = 9;
        end
      end
    end else begin
      if (left >= 2) begin
        bi = 9 - left;
        if (op_wr) m_mem[baddr(op_addr, bi)] = op_data[8*bi +: 8];
        if (left == 2) begin
          if (op_rd) begin
            for (int j = 0; j < 8; j++) m_valM[8*j +: 8] = m_mem[baddr(op_addr, j)];
          end
          m_err = 1'b0;
        end
      end
      left = left - 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, 64'(left > 0));
      chk("done", done, 64'(left == 1));
      chk("valM", valM, m_valM);
      chk("dmem_error", dmem_error, 64'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
    if (r <= 2) return 64'($urandom_range(MEM_BYTES - 16, MEM_BYTES + 16));
    return 64'($urandom_range(0, MEM_BYTES - 1));
  endfunction

  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    int guard;
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_before_issue", busy, 0);
    icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs so any failure to latch at the start edge shows up.
    start = 1'b0; icode = 4'($urandom); valE = rand64(); valA = rand64(); valP = rand64();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    chk("done_within_bound", done, 1);
  endtask

  task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, output int lat);
    issue(ic, e, a, p);
    wait_done(lat);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  lat;
    bit  seen_done;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valM", valM, 0);
    chk("reset_err", dmem_error, 0);

    // Fill memory so every later read has a known model value.
    for (int a = 0; a < MEM_BYTES; a += 8) run_op(4'h4, 64'(a), rand64(), 64'h0, lat);

    run_op(4'h4, 64'h0, 64'h0000_0000_0000_00C3, 64'h0, lat);
    run_op(4'h4, 64'h10, 64'h1122_3344_5566_7788, 64'h0, lat);
    chk("rmmovq_latency", 64'(lat), 9);
    chk("rmmovq_err", dmem_error, 0);
    run_op(4'h5, 64'h10, 64'h0, 64'h0, lat);
    chk("mrmovq_latency", 64'(lat), 9);
    chk("mrmovq_valM", valM, 64'h1122_3344_5566_7788);

    run_op(4'h8, 64'h3F8, 64'h0, 64'h2A, lat);
    chk("call_latency", 64'(lat), 9);
    run_op(4'h9, 64'h0, 64'h3F8, 64'h0, lat);
    chk("ret_valM", valM, 64'h2A);

    run_op(4'h6, 64'h10, 64'hFFFF, 64'h0, lat);
    chk("opq_latency", 64'(lat), 1);
    chk("opq_valM_held", valM, 64'h2A);
    run_op(4'h5, 64'h10, 64'h0, 64'h0, lat);
    chk("opq_no_write", valM, 64'h1122_3344_5566_7788);

    run_op(4'h5, 64'h3F9, 64'h0, 64'h0, lat);
    chk("edge_latency", 64'(lat), BC ? 64'd1 : 64'd9);
    chk("edge_err", dmem_error, BC ? 64'd1 : 64'd0);
    chk("edge_valM", valM, BC ? 64'h1122_3344_5566_7788 : 64'hC300_0000_0000_0000);

    // start raised during the done cycle is taken in the following idle cycle.
    icode = 4'h6; start = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", busy, 0);
    @(negedge clk);
    chk("start_after_done_taken", done, 1);
    start = 1'b0;

    // rst wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; icode = 4'h4; valE = 64'h10; valA = 64'h0;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_over_start_busy", busy, 0);
    run_op(4'h5, 64'h10, 64'h0, 64'h0, lat);
    chk("rst_over_start_no_write", valM, 64'h1122_3344_5566_7788);

    // Reset in the 4th transfer cycle of a pushq: three bytes land, no done.
    run_op(4'h4, 64'h40, 64'h0, 64'h0, lat);
    issue(4'hA, 64'h40, 64'h1122_3344_5566_7788, 64'h0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done |= done;
    end
    @(negedge clk);
    seen_done |= done;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", 64'(seen_done | done), 0);
    run_op(4'h5, 64'h40, 64'h0, 64'h0, lat);
    chk("abort_restart_latency", 64'(lat), 9);
    chk("abort_partial_bytes", valM, 64'h0000_0000_0066_7788);

    // Randomized traffic; inputs change every cycle regardless of busy.
    repeat (3000) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       icode = 4'h4;
        1:       icode = 4'h5;
        2:       icode = 4'h8;
        3:       icode = 4'h9;
        4:       icode = 4'hA;
        5:       icode = 4'hB;
        6:       icode = 4'h6;
        default: icode = 4'($urandom);
      endcase
      valE = rand_addr();
      valA = rand_addr();
      valP = rand64();
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning data-memory size in bytes (multiple of 8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  begin memory phase for current instruction.
REQ-005 SHALL have port icode  input  4  instruction code.
REQ-006 SHALL have port valE  input  64  execute-stage result (address for rmmovq/mrmovq/pushq/call).
REQ-007 SHALL have port valA  input  64  store data (rmmovq/pushq); address for popq/ret.
REQ-008 SHALL have port valP  input  64  return address stored by call.
REQ-009 SHALL have port busy  output  1  phase in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port valM  output  64  loaded word.
REQ-012 SHALL have port dmem_error  output  1  address fault for last phase.

Function
REQ-013 SHALL implement FSM IDLE -> XFER -> DONE -> IDLE; busy = (state != IDLE).
REQ-014 SHALL sample start only in IDLE and ignore it in XFER/DONE.
REQ-015 SHALL latch icode, address, and store data at the start edge; later input changes are ignored.
REQ-016 SHALL perform writes for icode 4 (addr valE, data valA), 0xA (addr valE, data valA), and 8 (addr valE, data valP).
REQ-017 SHALL perform reads for icode 5 (addr valE), 9 (addr valA), and 0xB (addr valA).
REQ-018 SHALL go IDLE -> DONE directly for any other icode, with no memory access and valM unchanged.
REQ-019 SHALL transfer one byte per XFER cycle, with 3-bit counter 0..7, little-endian (byte i = bits 8i+7:8i at addr+i).
REQ-020 SHALL, for an access started at edge k, run XFER in cycles k+1..k+8 and assert done in cycle k+9; for no access, assert done in cycle k+1.
REQ-021 SHALL update valM only at the DONE transition of a read, and hold it until the next read completes.
REQ-022 SHALL treat addresses as unsigned 64-bit; an access is in range iff addr <= MEM_BYTES-8, with no wrap.
REQ-023 SHALL, for an out-of-range access, go IDLE -> DONE, write nothing, leave valM unchanged, and set dmem_error.
REQ-024 SHALL update dmem_error at every DONE and hold it until the next DONE.
REQ-025 SHALL handle a start in the same cycle as done as a fresh start in the following IDLE cycle, never merged.

Reset
REQ-026 SHALL, on rst, force state IDLE, counter 0, busy 0, done 0, valM 0, and dmem_error 0 on the next edge.
REQ-027 SHALL, when rst is asserted mid-XFER, abort without asserting done; bytes already written remain.
REQ-028 SHALL NOT clear memory contents on rst.
REQ-029 SHALL give rst priority over a simultaneous start.

Configuration
REQ-030 SHALL, with DMEM_BOUNDS_CHECK_EN defined, apply REQ-022/023.
REQ-031 SHALL, without DMEM_BOUNDS_CHECK_EN, form byte addresses as (addr+i) mod MEM_BYTES, always run XFER, and tie dmem_error to 0.

Structure
REQ-032 SHALL take icode constants (ICODE_RMMOVQ=4, ICODE_MRMOVQ=5, ICODE_CALL=8, ICODE_RET=9, ICODE_PUSHQ=0xA, ICODE_POPQ=0xB) and the FSM state enum from shared package y86_pkg.
REQ-033 SHALL instantiate one sub-module dmem_byte_ram: byte-wide single-port RAM with synchronous write and combinational read, depth MEM_BYTES.

Verification
REQ-034 SHALL verify: rmmovq with valE=0x10, valA=0x1122334455667788 -> done at k+9; bytes 0x10..0x17 = 88,77,...,11; dmem_error=0.
REQ-035 SHALL verify: subsequent mrmovq with valE=0x10 -> valM=0x1122334455667788 at done.
REQ-036 SHALL verify: call with valE=0x3F8, valP=0x2A, then ret with valA=0x3F8 -> valM=0x2A.
REQ-037 SHALL verify: opq (icode 6) start -> done at k+1; valM unchanged; no write.
REQ-038 SHALL verify: mrmovq with valE=0x3F9 (MEM_BYTES=1024) -> with macro defined: dmem_error=1 and done at k+1; without macro: 8 XFER cycles, bytes 0x3F9..0x3FF and 0x000 read, dmem_error=0.
REQ-039 SHALL verify: rst asserted in 4th XFER cycle of pushq -> no done; busy=0 next cycle; first 3 bytes written; new start accepted afterwards.
